// File: rtl/bus_req_agent.sv
// Bus request agent: queues producer packets and presents them to the bus controller on grant.
// Latency: 2 cycles from push edge to bus_pkt_out (bus_req next cycle, packet the cycle after grant).
// Backpressure: in_rdy drops while DEPTH entries are held; a same-cycle pop does not reopen it.
package bus_req_agent_pkg;
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [15:0] payload;
  } bus_packet_t;
endpackage

module bus_req_agent
  import bus_req_agent_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  bus_packet_t              in_pkt,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic                     bus_req,
  input  logic                     bus_grant,
  output bus_packet_t              bus_pkt_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [STALL_W-1:0]       stall_cnt,
  output logic                     err_grant
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bus_packet_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          grant_d;
  logic          push;
  logic          pop;
  logic          grant_empty;

  // Ready is decoded from the registered count only, so it never depends on this cycle's pop.
  assign in_rdy      = (count < CW'(DEPTH));
  assign push        = in_vld & in_rdy;
  // grant_d means the bus samples the head entry this cycle; it pops unless the queue is empty.
  assign pop         = grant_d & (count != '0);
  assign grant_empty = grant_d & (count == '0);
  // The entry already committed to the bus is excluded from the request.
  assign bus_req     = (count > CW'(grant_d));
  assign bus_pkt_out = grant_d ? mem[rd_ptr] : '0;
  assign occupancy   = count;

  // Packet storage is written on push and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pkt;
    end
  end

  // Queue pointers, count, registered grant and the sticky empty-grant error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      grant_d   <= 1'b0;
      err_grant <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A grant is only honoured while we are actually requesting.
      grant_d <= bus_grant & bus_req;
      if (grant_empty) begin
        err_grant <= 1'b1;
      end
    end
  end

  // Saturating count of consecutive request-without-grant cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus_req && !bus_grant) begin
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bus_req_agent.sv
// Self-checking bench for bus_req_agent: table-driven cycle vectors plus a packet scoreboard.
// Each row drives one cycle of inputs and checks that cycle's registered outputs.
// Hand-written sequences cover stall saturation and reset during an in-flight grant.
module tb_bus_req_agent;
  import bus_req_agent_pkg::*;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 4;

  typedef struct {
    logic       vld;
    logic [7:0] id;
    logic       gnt;
    logic       rdy;
    logic       req;
    int         occ;
    int         stall;
    logic       err;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  bus_packet_t            in_pkt;
  logic                   in_vld;
  logic                   in_rdy;
  logic                   bus_req;
  logic                   bus_grant;
  bus_packet_t            bus_pkt_out;
  logic [$clog2(DEPTH):0] occupancy;
  logic [STALL_W-1:0]     stall_cnt;
  logic                   err_grant;

  int          n_chk  = 0;
  int          n_fail = 0;
  bus_packet_t sb[$];
  logic        exp_gd = 1'b0;
  vec_t        tbl[24];

  always #5 clk = ~clk;

  bus_req_agent #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_pkt(in_pkt), .in_vld(in_vld), .in_rdy(in_rdy),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_pkt_out(bus_pkt_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .err_grant(err_grant)
  );

  function automatic bus_packet_t mk_pkt(input logic [7:0] id);
    bus_packet_t p;
    p.src     = id[3:0];
    p.dst     = 4'hC;
    p.payload = {8'hA5, id};
    return p;
  endfunction

  function automatic vec_t mkv(input logic vld, input logic [7:0] id, input logic gnt,
                               input logic rdy, input logic req, input int occ,
                               input int stall, input logic err);
    vec_t v;
    v.vld = vld; v.id = id; v.gnt = gnt; v.rdy = rdy;
    v.req = req; v.occ = occ; v.stall = stall; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_rdy"},    32'(in_rdy),    32'd1);
    chk({tag, ".bus_req"},   32'(bus_req),   32'd0);
    chk({tag, ".pkt"},       {8'h0, bus_pkt_out}, 32'd0);
    chk({tag, ".occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, ".err_grant"}, 32'(err_grant), 32'd0);
  endtask

  // Drive one cycle, check this cycle's outputs, update the scoreboard, advance past the edge.
  task automatic apply_row(input vec_t v, input string tag);
    bus_packet_t exp_pkt;
    in_vld    = v.vld;
    in_pkt    = mk_pkt(v.id);
    bus_grant = v.gnt;
    #1;
    chk({tag, ".in_rdy"},    32'(in_rdy),    32'(v.rdy));
    chk({tag, ".bus_req"},   32'(bus_req),   32'(v.req));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(v.occ));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(v.stall));
    chk({tag, ".err_grant"}, 32'(err_grant), 32'(v.err));
    exp_pkt = '0;
    if (exp_gd) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.scoreboard: got empty queue expected a packet", tag);
      end else begin
        exp_pkt = sb.pop_front();
      end
    end
    chk({tag, ".pkt"}, {8'h0, bus_pkt_out}, {8'h0, exp_pkt});
    if (v.vld && v.rdy) sb.push_back(mk_pkt(v.id));
    exp_gd = v.gnt & v.req;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_packet_t exp_pkt;

    // Single packet with grant held high: request next cycle, packet two cycles after push.
    tbl[0]  = mkv(1, 8'd1, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 8'd0, 1, 1, 1, 1, 0, 0);
    tbl[2]  = mkv(0, 8'd0, 1, 1, 0, 1, 0, 0);
    tbl[3]  = mkv(0, 8'd0, 0, 1, 0, 0, 0, 0);
    // Fill without grant; fifth valid is refused; stall counts from the first request cycle.
    tbl[4]  = mkv(1, 8'd2, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 8'd3, 0, 1, 1, 1, 0, 0);
    tbl[6]  = mkv(1, 8'd4, 0, 1, 1, 2, 1, 0);
    tbl[7]  = mkv(1, 8'd5, 0, 1, 1, 3, 2, 0);
    tbl[8]  = mkv(1, 8'd6, 0, 0, 1, 4, 3, 0);
    tbl[9]  = mkv(1, 8'd6, 0, 0, 1, 4, 4, 0);
    // Burst drain: four accepted grants, the fifth arrives with bus_req low and is ignored.
    tbl[10] = mkv(0, 8'd0, 1, 0, 1, 4, 5, 0);
    tbl[11] = mkv(0, 8'd0, 1, 0, 1, 4, 0, 0);
    tbl[12] = mkv(0, 8'd0, 1, 1, 1, 3, 0, 0);
    tbl[13] = mkv(0, 8'd0, 1, 1, 1, 2, 0, 0);
    tbl[14] = mkv(0, 8'd0, 1, 1, 0, 1, 0, 0);
    tbl[15] = mkv(0, 8'd0, 0, 1, 0, 0, 0, 0);
    // Simultaneous push and pop at occupancy 2.
    tbl[16] = mkv(1, 8'd7, 0, 1, 0, 0, 0, 0);
    tbl[17] = mkv(1, 8'd8, 0, 1, 1, 1, 0, 0);
    tbl[18] = mkv(0, 8'd0, 1, 1, 1, 2, 1, 0);
    tbl[19] = mkv(1, 8'd9, 0, 1, 1, 2, 0, 0);
    tbl[20] = mkv(0, 8'd0, 1, 1, 1, 2, 1, 0);
    tbl[21] = mkv(0, 8'd0, 1, 1, 1, 2, 0, 0);
    tbl[22] = mkv(0, 8'd0, 0, 1, 0, 1, 0, 0);
    tbl[23] = mkv(0, 8'd0, 0, 1, 0, 0, 0, 0);

    // Reset with activity on the inputs: outputs must hold their reset values.
    rst_n     = 1'b0;
    in_vld    = 1'b1;
    bus_grant = 1'b1;
    in_pkt    = mk_pkt(8'd99);
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n     = 1'b1;
    in_vld    = 1'b0;
    bus_grant = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      apply_row(tbl[i], $sformatf("row%0d", i));
    end

    // Stall saturation: 20 cycles of request without grant, then a grant clears it.
    apply_row(mkv(1, 8'd10, 0, 1, 0, 0, 0, 0), "sat_push");
    for (int k = 0; k < 20; k++) begin
      apply_row(mkv(0, 8'd0, 0, 1, 1, 1, (k > 15) ? 15 : k, 0), $sformatf("sat%0d", k));
    end
    apply_row(mkv(0, 8'd0, 1, 1, 1, 1, 15, 0), "sat_grant");
    apply_row(mkv(0, 8'd0, 0, 1, 0, 1, 0, 0), "sat_clear");
    apply_row(mkv(0, 8'd0, 0, 1, 0, 0, 0, 0), "sat_empty");

    // Reset in the cycle after a grant with three packets queued.
    apply_row(mkv(1, 8'd11, 0, 1, 0, 0, 0, 0), "rst_push0");
    apply_row(mkv(1, 8'd12, 0, 1, 1, 1, 0, 0), "rst_push1");
    apply_row(mkv(1, 8'd13, 0, 1, 1, 2, 1, 0), "rst_push2");
    apply_row(mkv(0, 8'd0,  1, 1, 1, 3, 2, 0), "rst_grant");
    in_vld    = 1'b0;
    bus_grant = 1'b1;
    #1;
    exp_pkt = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("rst_pre.pkt", {8'h0, bus_pkt_out}, {8'h0, exp_pkt});
    chk("rst_pre.occupancy", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    sb.delete();
    exp_gd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst_hold");
    @(negedge clk);
    rst_n     = 1'b1;
    bus_grant = 1'b0;
    @(posedge clk);
    #1;
    apply_row(mkv(0, 8'd0, 1, 1, 0, 0, 0, 0), "post_rst0");
    apply_row(mkv(0, 8'd0, 0, 1, 0, 0, 0, 0), "post_rst1");
    apply_row(mkv(0, 8'd0, 0, 1, 0, 0, 0, 0), "post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
